adder_iter_rtl: RTL and testbench

Parametrised, multi-cycle ripple adder that computes a p_nbits-wide sum with carry-in and carry-out, p_chunk bits per cycle, behind latency-insensitive val/rdy interfaces. Successor to the single-bit combinational half adder: it is generalised in width, adds carry-in, and trades area for latency. It serves as the shared adder primitive for datapaths that can tolerate multi-cycle latency, and as a reference target for val/rdy test benches.

---
 rtl/adder_iter_rtl.sv | 81 ++++++++
 tb/tb_adder_iter_rtl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/adder_iter_rtl.sv
// adder_iter_rtl: multi-cycle ripple adder, p_chunk bits per cycle, behind val/rdy streams
module adder_iter_rtl #(
  parameter int p_nbits = 32,
  parameter int p_chunk = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [p_nbits-1:0] in_a,
  input  logic [p_nbits-1:0] in_b,
  input  logic               in_cin,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] out_sum,
  output logic               out_cout
);
  localparam int N = p_nbits / p_chunk;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [p_nbits-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_sh;
  logic carry_q, carry_d, c;
  logic [p_chunk-1:0] s;
  assign {c, s} = {1'b0, a_q[p_chunk-1:0]} + {1'b0, b_q[p_chunk-1:0]} + {{p_chunk{1'b0}}, carry_q};
  // New chunk enters at the top so the first chunk lands at bit 0 after N shifts
  generate
    if (p_chunk == p_nbits) begin : g_one
      assign sum_sh = s;
    end else begin : g_multi
      assign sum_sh = {s, sum_q[p_nbits-1:p_chunk]};
    end
  endgenerate
  assign istream_rdy = state_q == IDLE && !reset;
  assign ostream_val = state_q == DONE && !reset;
  assign out_sum     = sum_q;
  assign out_cout    = carry_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (state_q == IDLE && istream_val && istream_rdy) begin
      state_d = CALC;
      cnt_d   = '0;
      a_d     = in_a;
      b_d     = in_b;
      carry_d = in_cin;
    end else if (state_q == CALC) begin
      state_d = cnt_q == LAST ? DONE : CALC;
      cnt_d   = cnt_q + CW'(1);
      a_d     = a_q >> p_chunk;
      b_d     = b_q >> p_chunk;
      sum_d   = sum_sh;
      carry_d = c;
    end else if (state_q == DONE && ostream_rdy) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end
endmodule

// File: tb/tb_adder_iter_rtl.sv
// tb_adder_iter_rtl: directed checks on four parametrisations of adder_iter_rtl
module tb_adder_iter_rtl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] rst, ival, ordy, cin, irdy, oval, cout;
  logic [31:0] a [4];
  logic [31:0] b [4];
  logic [7:0]  s0;
  logic [0:0]  s1;
  logic [31:0] s2;
  logic [15:0] s3;
  int n_chk = 0, n_pass = 0;
  logic [16:0] exp_q [$];
  // instance 0: 8/4, 1: 1/1, 2: 32/4, 3: 16/2
  adder_iter_rtl #(.p_nbits(8), .p_chunk(4)) u0 (
    .clk(clk), .reset(rst[0]), .istream_val(ival[0]), .istream_rdy(irdy[0]),
    .in_a(a[0][7:0]), .in_b(b[0][7:0]), .in_cin(cin[0]), .ostream_val(oval[0]),
    .ostream_rdy(ordy[0]), .out_sum(s0), .out_cout(cout[0]));
  adder_iter_rtl #(.p_nbits(1), .p_chunk(1)) u1 (
    .clk(clk), .reset(rst[1]), .istream_val(ival[1]), .istream_rdy(irdy[1]),
    .in_a(a[1][0:0]), .in_b(b[1][0:0]), .in_cin(cin[1]), .ostream_val(oval[1]),
    .ostream_rdy(ordy[1]), .out_sum(s1), .out_cout(cout[1]));
  adder_iter_rtl #(.p_nbits(32), .p_chunk(4)) u2 (
    .clk(clk), .reset(rst[2]), .istream_val(ival[2]), .istream_rdy(irdy[2]),
    .in_a(a[2]), .in_b(b[2]), .in_cin(cin[2]), .ostream_val(oval[2]),
    .ostream_rdy(ordy[2]), .out_sum(s2), .out_cout(cout[2]));
  adder_iter_rtl #(.p_nbits(16), .p_chunk(2)) u3 (
    .clk(clk), .reset(rst[3]), .istream_val(ival[3]), .istream_rdy(irdy[3]),
    .in_a(a[3][15:0]), .in_b(b[3][15:0]), .in_cin(cin[3]), .ostream_val(oval[3]),
    .ostream_rdy(ordy[3]), .out_sum(s3), .out_cout(cout[3]));
  function automatic logic [31:0] sum_of(int k);
    return k == 0 ? {24'd0, s0} : k == 1 ? {31'd0, s1} : k == 2 ? s2 : {16'd0, s3};
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // Returns in the first cycle after the request handshake edge
  task automatic req(int k, logic [31:0] av, logic [31:0] bv, logic cv);
    int t = 0;
    @(negedge clk);
    ival[k] = 1'b1; a[k] = av; b[k] = bv; cin[k] = cv;
    while (!irdy[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("req_rdy", {63'd0, irdy[k]}, 64'd1);
    @(posedge clk);
    #1 ival[k] = 1'b0;
  endtask
  task automatic wait_val(int k, output int cyc);
    cyc = 1;
    while (!oval[k] && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask
  task automatic pop(int k);
    ordy[k] = 1'b1;
    @(posedge clk);
    #1 ordy[k] = 1'b0;
  endtask
  task automatic txn(int k, string tag, logic [31:0] av, logic [31:0] bv, logic cv,
                     logic [31:0] es, logic ec, int ecyc);
    int cyc;
    req(k, av, bv, cv);
    wait_val(k, cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(ecyc));
    check({tag, "_sum"}, {32'd0, sum_of(k)}, {32'd0, es});
    check({tag, "_cout"}, {63'd0, cout[k]}, {63'd0, ec});
    pop(k);
  endtask
  initial begin
    int cyc;
    logic seen;
    rst = 4'hF; ival = '0; ordy = '0; cin = '0;
    for (int i = 0; i < 4; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_irdy", {60'd0, irdy}, 64'h0);
    check("rst_oval", {60'd0, oval}, 64'h0);
    rst = '0;
    #1 check("post_rst_irdy", {60'd0, irdy}, 64'hF);
    txn(0, "8b_0f01", 32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, 3);
    txn(0, "8b_ff00c", 32'hFF, 32'h00, 1'b1, 32'h00, 1'b1, 3);
    txn(0, "8b_ff01", 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 3);
    txn(0, "8b_8080c", 32'h80, 32'h80, 1'b1, 32'h01, 1'b1, 3);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] e;
      v = 3'(i);
      e = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      txn(1, "fa", {31'd0, v[2]}, {31'd0, v[1]}, v[0], {31'd0, e[0]}, e[1], 2);
    end
    req(0, 32'h0F, 32'h01, 1'b0);
    wait_val(0, cyc);
    check("bp_lat", 64'(cyc), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_oval", {63'd0, oval[0]}, 64'd1);
      check("bp_sum", {56'd0, s0}, 64'h10);
      check("bp_irdy", {63'd0, irdy[0]}, 64'd0);
    end
    pop(0);
    check("bp_done_oval", {63'd0, oval[0]}, 64'd0);
    check("bp_done_irdy", {63'd0, irdy[0]}, 64'd1);
    req(2, 32'h1234_5678, 32'h0000_0001, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst[2] = 1'b1;
    #1;
    check("mid_rst_irdy", {63'd0, irdy[2]}, 64'd0);
    check("mid_rst_oval", {63'd0, oval[2]}, 64'd0);
    @(posedge clk);
    #1 rst[2] = 1'b0;
    #1 check("mid_rst_after_irdy", {63'd0, irdy[2]}, 64'd1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 seen |= oval[2];
    end
    check("mid_rst_no_result", {63'd0, seen}, 64'd0);
    txn(2, "32b_ffff", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b1, 9);
    fork
      for (int i = 0; i < 100; i++) begin
        logic [15:0] av, bv;
        logic cv;
        av = 16'($urandom);
        bv = 16'($urandom);
        cv = 1'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        exp_q.push_back({1'b0, av} + {1'b0, bv} + {16'd0, cv});
        req(3, {16'd0, av}, {16'd0, bv}, cv);
      end
      begin
        int got = 0, t = 0;
        while (got < 100 && t < 20000) begin
          @(negedge clk);
          t++;
          ordy[3] = 1'($urandom_range(0, 1));
          if (oval[3] && ordy[3]) begin
            got++;
            if (exp_q.size() == 0) check("rnd_extra", 64'd1, 64'd0);
            else check("rnd_sum", {47'd0, cout[3], s3}, {47'd0, exp_q.pop_front()});
          end
        end
        @(negedge clk) ordy[3] = 1'b0;
        check("rnd_count", 64'(got), 64'd100);
      end
    join
    check("rnd_left", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
